multi_counter: RTL and testbench

- Parametrised successor to the single free-running wrap counter.
- N independent counters of WIDTH bits each. Every channel has its own runtime-programmed terminal value and mode: up or down, wrap or saturate.
- Used as the event/timeout counter bank for the decoder control path.
- Emits a registered terminal-count pulse per channel.

---
 rtl/multi_counter_pkg.sv | 28 ++
 rtl/multi_counter_channel.sv | 81 ++++++++
 rtl/multi_counter.sv | 90 +++++++++
 tb/tb_multi_counter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_counter_pkg.sv
// Shared types, constants and helpers for the multi_counter event/timeout counter bank.
package multi_counter_pkg;

  // Encoding matches the cfg_mode port: bit0 = count down, bit1 = saturate.
  typedef enum logic [1:0] {
    UP_WRAP   = 2'b00,
    DOWN_WRAP = 2'b01,
    UP_SAT    = 2'b10,
    DOWN_SAT  = 2'b11
  } cnt_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } cfg_state_e;

  localparam logic [31:0] MC_DEFAULT_MAX = 32'h0000_0010;

  // A down counter starts from its terminal value, an up counter from zero.
  function automatic logic starts_at_max(cnt_mode_e mode);
    return (mode == DOWN_WRAP) || (mode == DOWN_SAT);
  endfunction

  function automatic logic is_saturating(cnt_mode_e mode);
    return (mode == UP_SAT) || (mode == DOWN_SAT);
  endfunction

endpackage

// File: rtl/multi_counter_channel.sv
// One WIDTH-bit counter channel: its own terminal value and mode, a
// config > clr > inc priority chain and a registered terminal-count pulse.
module counter_channel
  import multi_counter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_MAX = WIDTH'(MC_DEFAULT_MAX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_max,
  input  logic [1:0]       cfg_mode,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  cnt_mode_e        mode_q;
  cnt_mode_e        new_mode;
  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_up;
  logic [WIDTH-1:0] count_dn;
  logic             down;
  logic             sat;
  logic             tc_q;

  assign new_mode = cnt_mode_e'(cfg_mode);
  assign down     = starts_at_max(mode_q);
  assign sat      = is_saturating(mode_q);
  assign count_up = count_q + WIDTH'(1);
  assign count_dn = count_q - WIDTH'(1);

  // Counter state; a config write reloads the start value so count never exceeds max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q   <= RESET_MAX;
      mode_q  <= UP_WRAP;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else if (cfg_we) begin
      max_q   <= cfg_max;
      mode_q  <= new_mode;
      count_q <= starts_at_max(new_mode) ? cfg_max : '0;
      tc_q    <= 1'b0;
    end else if (clr) begin
      count_q <= down ? max_q : '0;
      tc_q    <= 1'b0;
    end else if (inc) begin
      if (!down) begin
        if (count_q != max_q) begin
          count_q <= count_up;
          tc_q    <= sat && (count_up == max_q);
        end else if (!sat) begin
          count_q <= '0;
          tc_q    <= 1'b1;
        end else begin
          tc_q    <= 1'b0;
        end
      end else begin
        if (count_q != '0) begin
          count_q <= count_dn;
          tc_q    <= sat && (count_dn == '0);
        end else if (!sat) begin
          count_q <= max_q;
          tc_q    <= 1'b1;
        end else begin
          tc_q    <= 1'b0;
        end
      end
    end else begin
      tc_q <= 1'b0;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: rtl/multi_counter.sv
// Bank of NUM_CH independent event/timeout counters with a one-request
// config port. Optional sticky overflow flags under MULTI_COUNTER_OVF_STICKY_EN.
module multi_counter
  import multi_counter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter logic [WIDTH-1:0] DEFAULT_MAX = WIDTH'(MC_DEFAULT_MAX),
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [WIDTH-1:0]        cfg_max,
  input  logic [1:0]              cfg_mode,
  input  logic [NUM_CH-1:0]       inc,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH*WIDTH-1:0] count,
`ifdef MULTI_COUNTER_OVF_STICKY_EN
  output logic [NUM_CH-1:0]       ovf,
  input  logic [NUM_CH-1:0]       ovf_clr,
`endif
  output logic [NUM_CH-1:0]       tc
);

  cfg_state_e        state;
  logic              accept;
  logic [NUM_CH-1:0] ch_we;

  assign accept = cfg_valid && cfg_ready;

  // Handshake FSM: after each accept, cfg_ready is held low for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cfg_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            state     <= APPLY;
            cfg_ready <= 1'b0;
          end
        end
        APPLY: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  // An out-of-range channel index matches no decode line, so the write is dropped.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_we[gi] = accept && (cfg_ch == CH_W'(gi));

    counter_channel #(
      .WIDTH     (WIDTH),
      .RESET_MAX (DEFAULT_MAX)
    ) u_channel (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (ch_we[gi]),
      .cfg_max  (cfg_max),
      .cfg_mode (cfg_mode),
      .inc      (inc[gi]),
      .clr      (clr[gi]),
      .count    (count[gi*WIDTH +: WIDTH]),
      .tc       (tc[gi])
    );
  end

`ifdef MULTI_COUNTER_OVF_STICKY_EN
  // Sticky overflow: set by a visible tc pulse, which beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= '0;
    end else begin
      ovf <= tc | (ovf & ~ovf_clr);
    end
  end
`endif

endmodule

// File: tb/tb_multi_counter.sv
// Self-checking bench for multi_counter. Expectations are hand-derived constants
// queued as stimulus is driven and popped one cycle later when outputs settle.
// Define MULTI_COUNTER_OVF_STICKY_EN to also exercise the sticky overflow flags.
module tb_multi_counter;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 32;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [1:0]              cfg_ch;
  logic [WIDTH-1:0]        cfg_max;
  logic [1:0]              cfg_mode;
  logic [NUM_CH-1:0]       inc;
  logic [NUM_CH-1:0]       clr;
  logic [NUM_CH*WIDTH-1:0] count;
  logic [NUM_CH-1:0]       tc;
`ifdef MULTI_COUNTER_OVF_STICKY_EN
  logic [NUM_CH-1:0]       ovf;
  logic [NUM_CH-1:0]       ovf_clr;
`endif

  multi_counter #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_max   (cfg_max),
    .cfg_mode  (cfg_mode),
    .inc       (inc),
    .clr       (clr),
    .count     (count),
`ifdef MULTI_COUNTER_OVF_STICKY_EN
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
`endif
    .tc        (tc)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          ch;
    logic [31:0] count;
    logic [3:0]  tc;
    logic        ready;
    logic        chk_ovf;
    logic        ovf;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  inc;
    logic [3:0]  clr;
    logic        cfg_valid;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_max;
    logic [1:0]  cfg_mode;
    int          ch;
    logic [31:0] count;
    logic [3:0]  tc;
    logic        ready;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[20];
  int   checks   = 0;
  int   failures = 0;

  task automatic checkValue(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", nm, act, expv);
    end
  endtask

  task automatic applyStimulus(input string nm, input logic [3:0] i_inc, input logic [3:0] i_clr,
                               input logic v, input logic [1:0] ch, input logic [31:0] mx,
                               input logic [1:0] md, input int ech, input logic [31:0] ecount,
                               input logic [3:0] etc, input logic erdy, input logic covf,
                               input logic eovf);
    exp_t e;
    inc       = i_inc;
    clr       = i_clr;
    cfg_valid = v;
    cfg_ch    = ch;
    cfg_max   = mx;
    cfg_mode  = md;
    e = '{nm, ech, ecount, etc, erdy, covf, eovf};
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard actual=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      checkValue({e.name, ".count"}, count[e.ch*WIDTH +: WIDTH], e.count);
      checkValue({e.name, ".tc"}, 32'(tc), 32'(e.tc));
      checkValue({e.name, ".ready"}, 32'(cfg_ready), 32'(e.ready));
`ifdef MULTI_COUNTER_OVF_STICKY_EN
      if (e.chk_ovf) checkValue({e.name, ".ovf"}, 32'(ovf[e.ch]), 32'(e.ovf));
`endif
    end
  endtask

  task automatic step(input string nm, input logic [3:0] i_inc, input logic [3:0] i_clr,
                      input logic v, input logic [1:0] ch, input logic [31:0] mx,
                      input logic [1:0] md, input int ech, input logic [31:0] ecount,
                      input logic [3:0] etc, input logic erdy, input logic covf, input logic eovf);
    applyStimulus(nm, i_inc, i_clr, v, ch, mx, md, ech, ecount, etc, erdy, covf, eovf);
    checkOutput();
  endtask

  initial begin
    // Vector table: down/wrap on ch1, clr priority, down/saturate on ch3, max=0 up/wrap on ch2.
    vecs[0]  = '{"dw.cfg",  4'b0000, 4'b0000, 1'b1, 2'd1, 32'd5, 2'd1, 1, 32'd5, 4'b0000, 1'b0};
    vecs[1]  = '{"dw.gap",  4'b0000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 1, 32'd5, 4'b0000, 1'b1};
    vecs[2]  = '{"dw.i1",   4'b0010, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 1, 32'd4, 4'b0000, 1'b1};
    vecs[3]  = '{"dw.i2",   4'b0010, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 1, 32'd3, 4'b0000, 1'b1};
    vecs[4]  = '{"dw.i3",   4'b0010, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 1, 32'd2, 4'b0000, 1'b1};
    vecs[5]  = '{"dw.i4",   4'b0010, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 1, 32'd1, 4'b0000, 1'b1};
    vecs[6]  = '{"dw.i5",   4'b0010, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 1, 32'd0, 4'b0000, 1'b1};
    vecs[7]  = '{"dw.i6",   4'b0010, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 1, 32'd5, 4'b0010, 1'b1};
    vecs[8]  = '{"dw.i7",   4'b0010, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 1, 32'd4, 4'b0000, 1'b1};
    vecs[9]  = '{"dw.clr",  4'b0010, 4'b0010, 1'b0, 2'd0, 32'd0, 2'd0, 1, 32'd5, 4'b0000, 1'b1};
    vecs[10] = '{"ds.cfg",  4'b1000, 4'b0000, 1'b1, 2'd3, 32'd2, 2'd3, 3, 32'd2, 4'b0000, 1'b0};
    vecs[11] = '{"ds.i1",   4'b1000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 3, 32'd1, 4'b0000, 1'b1};
    vecs[12] = '{"ds.i2",   4'b1000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 3, 32'd0, 4'b1000, 1'b1};
    vecs[13] = '{"ds.i3",   4'b1000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 3, 32'd0, 4'b0000, 1'b1};
    vecs[14] = '{"ds.clr",  4'b0000, 4'b1000, 1'b0, 2'd0, 32'd0, 2'd0, 3, 32'd2, 4'b0000, 1'b1};
    vecs[15] = '{"z.cfg",   4'b0000, 4'b0000, 1'b1, 2'd2, 32'd0, 2'd0, 2, 32'd0, 4'b0000, 1'b0};
    vecs[16] = '{"z.i1",    4'b0100, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 2, 32'd0, 4'b0100, 1'b1};
    vecs[17] = '{"z.i2",    4'b0100, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 2, 32'd0, 4'b0100, 1'b1};
    vecs[18] = '{"z.idle",  4'b0000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 2, 32'd0, 4'b0000, 1'b1};
    vecs[19] = '{"dw.hold", 4'b0000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 1, 32'd5, 4'b0000, 1'b1};

    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_max   = '0;
    cfg_mode  = '0;
    inc       = '0;
    clr       = '0;
`ifdef MULTI_COUNTER_OVF_STICKY_EN
    ovf_clr   = '0;
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) checkValue($sformatf("reset.count%0d", i), count[i*WIDTH +: WIDTH], 32'd0);
    checkValue("reset.tc", 32'(tc), 32'd0);
    checkValue("reset.ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;

    // Default max 0x10 on ch0: 16 steps up, wrap on the 17th with tc, then 1.
    for (int k = 1; k <= 18; k++) begin
      step($sformatf("dflt.k%0d", k), 4'b0001, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 0,
           (k <= 16) ? 32'(k) : 32'(k - 17), (k == 17) ? 4'b0001 : 4'b0000, 1'b1, 1'b0, 1'b0);
    end

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].name, vecs[i].inc, vecs[i].clr, vecs[i].cfg_valid, vecs[i].cfg_ch,
           vecs[i].cfg_max, vecs[i].cfg_mode, vecs[i].ch, vecs[i].count, vecs[i].tc,
           vecs[i].ready, 1'b0, 1'b0);
    end

    // Up/saturate on ch2 with max 3: sticks at 3, tc exactly once.
    step("us.cfg", 4'b0000, 4'b0000, 1'b1, 2'd2, 32'd3, 2'd2, 2, 32'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step($sformatf("us.k%0d", k), 4'b0100, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 2,
           (k < 3) ? 32'(k) : 32'd3, (k == 3) ? 4'b0100 : 4'b0000, 1'b1, 1'b0, 1'b0);
    end

    // Config beats clr and inc; cfg_valid held through the ready-low cycle is taken once.
    step("pri.cfg",  4'b0001, 4'b0001, 1'b1, 2'd0, 32'd7, 2'd1, 0, 32'd7, 4'b0000, 1'b0, 1'b0, 1'b0);
    step("pri.hold", 4'b0001, 4'b0000, 1'b1, 2'd0, 32'd7, 2'd1, 0, 32'd6, 4'b0000, 1'b1, 1'b0, 1'b0);
    step("pri.done", 4'b0000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 0, 32'd6, 4'b0000, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-config and mid-count.
    step("rst.cfg", 4'b0001, 4'b0000, 1'b1, 2'd0, 32'd9, 2'd1, 0, 32'd9, 4'b0000, 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NUM_CH; i++) checkValue($sformatf("rst.async.count%0d", i), count[i*WIDTH +: WIDTH], 32'd0);
    checkValue("rst.async.tc", 32'(tc), 32'd0);
    checkValue("rst.async.ready", 32'(cfg_ready), 32'd1);
`ifdef MULTI_COUNTER_OVF_STICKY_EN
    checkValue("rst.async.ovf", 32'(ovf), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    checkValue("rst.held.count0", count[WIDTH-1:0], 32'd0);
    checkValue("rst.held.ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    step("rst.release", 4'b0001, 4'b0000, 1'b1, 2'd0, 32'd9, 2'd1, 0, 32'd9, 4'b0000, 1'b0, 1'b0, 1'b0);
    step("rst.idle",    4'b0000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 0, 32'd9, 4'b0000, 1'b1, 1'b0, 1'b0);

    // ch1 was down/wrap max 5 before reset; it must be back to up/wrap max 0x10.
    for (int k = 1; k <= 17; k++) begin
      step($sformatf("rmax.k%0d", k), 4'b0010, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 1,
           (k <= 16) ? 32'(k) : 32'd0, (k == 17) ? 4'b0010 : 4'b0000, 1'b1, 1'b0, 1'b0);
    end

`ifdef MULTI_COUNTER_OVF_STICKY_EN
    // Sticky overflow on ch3: set by tc, cleared by ovf_clr, set wins over clear.
    step("ovf.cfg", 4'b0000, 4'b0000, 1'b1, 2'd3, 32'd1, 2'd0, 3, 32'd0, 4'b0000, 1'b0, 1'b1, 1'b0);
    step("ovf.i1",  4'b1000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 3, 32'd1, 4'b0000, 1'b1, 1'b1, 1'b0);
    step("ovf.i2",  4'b1000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 3, 32'd0, 4'b1000, 1'b1, 1'b1, 1'b0);
    step("ovf.set", 4'b0000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 3, 32'd0, 4'b0000, 1'b1, 1'b1, 1'b1);
    step("ovf.hold", 4'b0000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 3, 32'd0, 4'b0000, 1'b1, 1'b1, 1'b1);
    ovf_clr = 4'b1000;
    step("ovf.clr", 4'b0000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 3, 32'd0, 4'b0000, 1'b1, 1'b1, 1'b0);
    ovf_clr = 4'b0000;
    step("ovf.i3",  4'b1000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 3, 32'd1, 4'b0000, 1'b1, 1'b1, 1'b0);
    step("ovf.i4",  4'b1000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 3, 32'd0, 4'b1000, 1'b1, 1'b1, 1'b0);
    ovf_clr = 4'b1000;
    step("ovf.race", 4'b0000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 3, 32'd0, 4'b0000, 1'b1, 1'b1, 1'b1);
    ovf_clr = 4'b0000;
    step("ovf.keep", 4'b0000, 4'b0000, 1'b0, 2'd0, 32'd0, 2'd0, 3, 32'd0, 4'b0000, 1'b1, 1'b1, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
